// File: rtl/ms_ff_pkg.sv
// Shared types for the master-slave SR flip-flop: request decoding used by every lane.
package ms_ff_pkg;

  typedef enum logic [1:0] {
    SR_HOLD,
    SR_SET,
    SR_RESET,
    SR_BOTH
  } sr_cmd_e;

  function automatic sr_cmd_e decode_sr(input logic s, input logic r);
    case ({s, r})
      2'b10:   return SR_SET;
      2'b01:   return SR_RESET;
      2'b11:   return SR_BOTH;
      default: return SR_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/sr_master_latch.sv
// One-lane gated SR latch forming the master stage; transparent while EN is high.
// With MS_FF_RESET_PRIORITY_EN defined, S=R=1 clears the latch; otherwise it holds.
module sr_master_latch
  import ms_ff_pkg::*;
(
  input  logic EN,
  input  logic RST_L,
  input  logic S,
  input  logic R,
  output logic P
);

  // Level-sensitive so that any request during the open phase is captured; last request wins.
  always_latch begin
    if (EN) begin
      if (!RST_L) begin
        P <= 1'b0;
      end else begin
        case (decode_sr(S, R))
          SR_SET:   P <= 1'b1;
          SR_RESET: P <= 1'b0;
`ifdef MS_FF_RESET_PRIORITY_EN
          SR_BOTH:  P <= 1'b0;
`endif
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ms_ff.sv
// WIDTH-lane master-slave SR flip-flop: latch masters open while CLK=1, slave loads on CLK fall.
// Optional build macro MS_FF_RESET_PRIORITY_EN makes S=R=1 clear the master.
module ms_ff
  import ms_ff_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST_L,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] P_L,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_L
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    sr_master_latch u_master (
      .EN    (CLK),
      .RST_L (RST_L),
      .S     (S[i]),
      .R     (R[i]),
      .P     (P[i])
    );
  end

  // A low RST_L at the falling edge has already held the open master at 0,
  // so the slave only needs its own synchronous clear here.
  always_ff @(negedge CLK) begin
    if (!RST_L) begin
      Q <= '0;
    end else begin
      Q <= P;
    end
  end

  assign P_L = ~P;
  assign Q_L = ~Q;

endmodule

// File: tb/tb_ms_ff.sv
// Randomised scoreboard bench for ms_ff (WIDTH=4); expected Q/P queued per cycle, popped after each falling edge.
module tb_ms_ff;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] p;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_l;
  logic [W-1:0] s, r;
  logic [W-1:0] p_out, p_l_out, q_out, q_l_out;

  logic [W-1:0] mp, mq;
  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_fail = 0;

  ms_ff #(.WIDTH(W)) dut (
    .CLK   (clk),
    .RST_L (rst_l),
    .S     (s),
    .R     (r),
    .P     (p_out),
    .P_L   (p_l_out),
    .Q     (q_out),
    .Q_L   (q_l_out)
  );

  always #100 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference behaviour of an open master: rules applied to the current S/R/RST_L per lane.
  task automatic model_eval();
    for (int i = 0; i < W; i++) begin
      if (!rst_l) mp[i] = 1'b0;
      else if (s[i] && !r[i]) mp[i] = 1'b1;
      else if (r[i] && !s[i]) mp[i] = 1'b0;
      else if (s[i] && r[i]) begin
`ifdef MS_FF_RESET_PRIORITY_EN
        mp[i] = 1'b0;
`endif
      end
    end
  endtask

  // One full cycle, entered just after a falling edge: low-phase noise, pre-edge values,
  // three high-phase request changes, then the expected edge result is queued.
  task automatic applyStimulus(input logic rst_val,
                               input logic [W-1:0] low_s, input logic [W-1:0] low_r,
                               input logic [W-1:0] pre_s, input logic [W-1:0] pre_r,
                               input logic [3*W-1:0] ev_s, input logic [3*W-1:0] ev_r);
    exp_t e;
    #20;
    rst_l = rst_val;
    s = low_s;
    r = low_r;
    #20;
    checkOutput("p_low_phase", p_out, mp);
    checkOutput("q_low_phase", q_out, mq);
    #10;
    s = pre_s;
    r = pre_r;
    @(posedge clk);
    model_eval();
    #10;
    checkOutput("p_rise", p_out, mp);
    checkOutput("q_hold_rise", q_out, mq);
    for (int k = 0; k < 3; k++) begin
      #15;
      s = ev_s[k*W +: W];
      r = ev_r[k*W +: W];
      model_eval();
      #5;
      checkOutput("p_high", p_out, mp);
      checkOutput("p_l_high", p_l_out, ~mp);
    end
    #20;
    e.q = rst_l ? mp : '0;
    if (!rst_l) mp = '0;
    e.p = mp;
    mq = e.q;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("q_fall", q_out, e.q);
        checkOutput("q_l_fall", q_l_out, ~e.q);
        checkOutput("p_fall", p_out, e.p);
      end
    end
  end

  initial begin : stimulus
    localparam logic [W-1:0] ALL = '1;
    localparam logic [W-1:0] NONE = '0;
    rst_l = 1'b0;
    s = '0;
    r = '0;
    mp = '0;
    mq = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_p", p_out, NONE);
    checkOutput("reset_p_l", p_l_out, ALL);
    checkOutput("reset_q", q_out, NONE);
    checkOutput("reset_q_l", q_l_out, ALL);

    $display("[TB] directed cases");
    applyStimulus(1'b1, NONE, NONE, ALL, NONE, {NONE, NONE, ALL}, {NONE, NONE, NONE});
    applyStimulus(1'b1, NONE, NONE, NONE, NONE, {NONE, NONE, NONE}, {NONE, ALL, NONE});
    applyStimulus(1'b1, NONE, NONE, NONE, NONE, {NONE, NONE, ALL}, {NONE, NONE, NONE});
    applyStimulus(1'b1, NONE, ALL, NONE, NONE, {NONE, NONE, NONE}, {NONE, NONE, NONE});
    applyStimulus(1'b0, NONE, NONE, ALL, NONE, {ALL, ALL, ALL}, {NONE, NONE, NONE});
    applyStimulus(1'b1, ALL, NONE, NONE, NONE, {NONE, NONE, NONE}, {NONE, NONE, NONE});
    applyStimulus(1'b1, NONE, NONE, ALL, NONE, {NONE, NONE, NONE}, {NONE, NONE, NONE});
    applyStimulus(1'b1, NONE, NONE, NONE, NONE, {NONE, ALL, ALL}, {NONE, ALL, ALL});
    applyStimulus(1'b1, NONE, NONE, 4'b0101, 4'b1010,
                  {4'b0000, 4'b0011, 4'b1000}, {4'b0000, 4'b0110, 4'b0001});
    applyStimulus(1'b1, 4'b1111, 4'b0000, 4'b1100, 4'b1100,
                  {4'b0001, 4'b0000, 4'b0010}, {4'b0000, 4'b1000, 4'b0010});

    $display("[TB] random cases");
    for (int n = 0; n < 150; n++) begin
      applyStimulus(($urandom_range(0, 15) != 0),
                    W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                    (3*W)'($urandom), (3*W)'($urandom));
    end

    @(negedge clk);
    #5;
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
